fifo_capture_ctrl: RTL and testbench
====================================

Name: fifo_capture_ctrl

Overview:
- Single-clock sequencer for one 12-bit capture FIFO bank (12 x fifo8k_by_1, 8192 words deep) in the ADC write-clock domain.
- Flushes the FIFO, waits for a trigger, applies a programmable post-trigger delay, then drives wren for exactly N samples and reports completion.
- Host readout on rdclk/rden is outside this block; host polls busy/done through its own synchroniser.

Parameters:
- DEPTH, 8192, FIFO depth in words; maximum capture length.
- CNT_W, 14, width of sample_count and wr_count; must hold DEPTH.
- DLY_W, 16, width of trig_delay.
- RST_CYCLES, 8, number of cycles fifo_rst is held high during flush; minimum 1.

Ports:
- wrclk  in  1  capture clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  start a capture; sampled only in IDLE or DONE.
- abort  in  1  cancel a capture from any state.
- trig  in  1  capture trigger, level-sensitive by default.
- sample_count  in  CNT_W  requested capture length; latched on accepted arm.
- trig_delay  in  DLY_W  cycles between trigger and first write; latched on accepted arm.
- fifo_rst  out  1  reset to the FIFO bank.
- wren  out  1  FIFO write enable.
- busy  out  1  high in FLUSH, WAIT_TRIG, DELAY and CAPTURE.
- done  out  1  high in DONE.
- clamped  out  1  latched request exceeded DEPTH.
- wr_count  out  CNT_W  words written in the current or last capture.
- state  out  3  IDLE=0, FLUSH=1, WAIT_TRIG=2, DELAY=3, CAPTURE=4, DONE=5.

Behaviour:
- Reset state: IDLE. All outputs 0: fifo_rst, wren, busy, done, clamped, wr_count, state. Reset mid-capture stops wren on the next edge; no partial done.
- Length rule on accepted arm:
  - N = DEPTH if sample_count == 0 or sample_count > DEPTH.
  - clamped = 1 only if sample_count > DEPTH; otherwise N = sample_count and clamped = 0.
- IDLE / DONE, arm = 1:
  - Latch N and trig_delay; clear wr_count and done; go to FLUSH.
  - arm in any other state is ignored.
- FLUSH:
  - fifo_rst = 1 for exactly RST_CYCLES cycles, starting the cycle after arm.
  - Then go to WAIT_TRIG with fifo_rst = 0.
  - trig during FLUSH is ignored.
- WAIT_TRIG, trig = 1 at cycle t:
  - If the latched delay is 0, go to CAPTURE; first wren at t+1.
  - Otherwise go to DELAY; first wren at t+1+D.
- DELAY: down-counter runs D cycles, then go to CAPTURE. trig is ignored.
- CAPTURE:
  - wren = 1 for exactly N consecutive cycles; wr_count increments on each wren cycle.
  - After the Nth write, go to DONE. wren is low on the cycle after the Nth write.
- DONE: done = 1 and busy = 0; hold wr_count = N until the next accepted arm.
- abort = 1 in any state:
  - Next state is IDLE; wren and fifo_rst drop next cycle.
  - wr_count holds the partial count; done stays 0.
  - abort has priority over arm, trig and counter terminal events in the same cycle.
- Simultaneous arm and abort: abort wins; stay in or return to IDLE.
- Counter width: the wr_count terminal compare is against N; no wrap is possible because N <= DEPTH < 2^CNT_W.

Optional Feature:
- Macro: FIFO_CAPTURE_TRIG_EDGE_EN.
- Defined: trig is registered, and WAIT_TRIG advances only on a rising edge (trig = 1 and previous trig = 0). A trig already high on entry to WAIT_TRIG does not fire until it falls and rises again. The first-write latency from the edge cycle is unchanged (t+1+D).
- Undefined: level-sensitive as described in Behaviour; trig high on the first WAIT_TRIG cycle fires immediately.

Test Plan:
- Basic capture: reset, then sample_count=16, trig_delay=0, arm at cycle 0, trig high at cycle 12 -> fifo_rst high cycles 1-8; wren high cycles 13-28; done=1 from cycle 29; wr_count=16; clamped=0.
- Delay: sample_count=4, trig_delay=5, trigger at cycle t -> wren high t+6..t+9; state passes through 3 for exactly 5 cycles.
- Length bounds:
  - sample_count=0 -> 8192 wren cycles, clamped=0.
  - sample_count=10000 -> 8192 wren cycles, clamped=1, wr_count=8192.
- Abort and re-arm: abort on the 100th wren cycle of a 1000-sample capture -> wren low next cycle, state=0, done=0, wr_count=100. A following arm restarts with a fresh FLUSH.
- Ignored arm and trig: arm pulse during CAPTURE and trig during FLUSH -> no effect; the capture length and timing match the basic case.
- Edge mode (macro defined): trig held high through FLUSH -> no capture until trig falls and rises; first wren one cycle after the rising edge. Same stimulus without the macro -> capture starts on the first WAIT_TRIG cycle.

Source files
------------

// File: rtl/fifo_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_capture_ctrl_if
// Control/status bundle between a capture host and fifo_capture_ctrl.
//   master : drives arm, abort, trig, sample_count, trig_delay;
//            observes fifo_rst, wren, busy, done, clamped, wr_count, state.
//   slave  : the capture controller (mirror image of master).
// Parameters:
//   CNT_W : width of sample_count / wr_count
//   DLY_W : width of trig_delay
// ----------------------------------------------------------------------------
interface fifo_capture_ctrl_if #(
  parameter int CNT_W = 14,
  parameter int DLY_W = 16
);
  logic             arm;
  logic             abort;
  logic             trig;
  logic [CNT_W-1:0] sample_count;
  logic [DLY_W-1:0] trig_delay;
  logic             fifo_rst;
  logic             wren;
  logic             busy;
  logic             done;
  logic             clamped;
  logic [CNT_W-1:0] wr_count;
  logic [2:0]       state;

  modport master (
    output arm, abort, trig, sample_count, trig_delay,
    input  fifo_rst, wren, busy, done, clamped, wr_count, state
  );

  modport slave (
    input  arm, abort, trig, sample_count, trig_delay,
    output fifo_rst, wren, busy, done, clamped, wr_count, state
  );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_capture_ctrl
// Single-clock sequencer for a 12-bit capture FIFO bank in the ADC write-clock
// domain: flush the FIFO, wait for a trigger, wait a programmable delay, then
// assert wren for exactly N samples and report completion.
//
// Ports:
//   wrclk : capture clock, all logic on the rising edge
//   rst   : synchronous active-high reset
//   bus   : fifo_capture_ctrl_if.slave
//           in  arm, abort, trig, sample_count[CNT_W], trig_delay[DLY_W]
//           out fifo_rst, wren, busy, done, clamped, wr_count[CNT_W], state[3]
//
// Build option:
//   FIFO_CAPTURE_TRIG_EDGE_EN - when defined, trig is registered and only a
//   rising edge seen in WAIT_TRIG starts the capture; otherwise trig is
//   level-sensitive.
//
// All outputs are registered. Status flags are decoded from the next state so
// they line up exactly with the state register.
// ----------------------------------------------------------------------------
module fifo_capture_ctrl #(
  parameter int DEPTH      = 8192,
  parameter int CNT_W      = 14,
  parameter int DLY_W      = 16,
  parameter int RST_CYCLES = 8
) (
  input logic               wrclk,
  input logic               rst,
  fifo_capture_ctrl_if.slave bus
);

  localparam int FL_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_DELAY     = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t           state_r,     state_nxt_s;
  logic [CNT_W-1:0] n_r,         n_nxt_s;
  logic [DLY_W-1:0] dly_r,       dly_nxt_s;
  logic [DLY_W-1:0] dly_cnt_r,   dly_cnt_nxt_s;
  logic [FL_W-1:0]  flush_cnt_r, flush_cnt_nxt_s;
  logic [CNT_W-1:0] wr_count_r,  wr_count_nxt_s;
  logic             clamped_r,   clamped_nxt_s;
  logic             fifo_rst_r;
  logic             wren_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] len_s;
  logic             over_s;
  logic [CNT_W-1:0] wr_inc_s;
  logic             fire_s;

  // Capture length from the request: zero or oversize requests mean a full FIFO.
  always_comb begin
    over_s = (bus.sample_count > CNT_W'(DEPTH));
    if (over_s || (bus.sample_count == CNT_W'(0))) begin
      len_s = CNT_W'(DEPTH);
    end else begin
      len_s = bus.sample_count;
    end
  end

`ifdef FIFO_CAPTURE_TRIG_EDGE_EN
  logic trig_q_r;

  // Previous-cycle trig, used to detect a rising edge.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      trig_q_r <= 1'b0;
    end else begin
      trig_q_r <= bus.trig;
    end
  end

  assign fire_s = bus.trig & ~trig_q_r;
`else
  assign fire_s = bus.trig;
`endif

  // wren is high in every CAPTURE cycle, so the count after this cycle's write.
  assign wr_inc_s = wr_count_r + CNT_W'(1);

  // Next-state and datapath update; abort overrides every other event.
  always_comb begin
    state_nxt_s     = state_r;
    n_nxt_s         = n_r;
    dly_nxt_s       = dly_r;
    dly_cnt_nxt_s   = dly_cnt_r;
    flush_cnt_nxt_s = flush_cnt_r;
    clamped_nxt_s   = clamped_r;
    // A write that happened this cycle is always counted, even when aborting.
    if (wren_r) begin
      wr_count_nxt_s = wr_inc_s;
    end else begin
      wr_count_nxt_s = wr_count_r;
    end

    if (bus.abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            state_nxt_s     = ST_FLUSH;
            n_nxt_s         = len_s;
            clamped_nxt_s   = over_s;
            dly_nxt_s       = bus.trig_delay;
            wr_count_nxt_s  = CNT_W'(0);
            flush_cnt_nxt_s = FL_W'(RST_CYCLES);
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == FL_W'(1)) begin
            state_nxt_s = ST_WAIT_TRIG;
          end else begin
            flush_cnt_nxt_s = flush_cnt_r - FL_W'(1);
          end
        end
        ST_WAIT_TRIG: begin
          if (fire_s) begin
            if (dly_r == DLY_W'(0)) begin
              state_nxt_s = ST_CAPTURE;
            end else begin
              state_nxt_s   = ST_DELAY;
              dly_cnt_nxt_s = dly_r;
            end
          end else begin
            state_nxt_s = ST_WAIT_TRIG;
          end
        end
        ST_DELAY: begin
          // Counter holds the remaining DELAY cycles including this one.
          if (dly_cnt_r == DLY_W'(1)) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            dly_cnt_nxt_s = dly_cnt_r - DLY_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (wr_inc_s == n_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      n_r         <= CNT_W'(0);
      dly_r       <= DLY_W'(0);
      dly_cnt_r   <= DLY_W'(0);
      flush_cnt_r <= FL_W'(0);
      wr_count_r  <= CNT_W'(0);
      clamped_r   <= 1'b0;
      fifo_rst_r  <= 1'b0;
      wren_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      n_r         <= n_nxt_s;
      dly_r       <= dly_nxt_s;
      dly_cnt_r   <= dly_cnt_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      wr_count_r  <= wr_count_nxt_s;
      clamped_r   <= clamped_nxt_s;
      fifo_rst_r  <= (state_nxt_s == ST_FLUSH);
      wren_r      <= (state_nxt_s == ST_CAPTURE);
      busy_r      <= (state_nxt_s == ST_FLUSH)     || (state_nxt_s == ST_WAIT_TRIG) ||
                     (state_nxt_s == ST_DELAY)     || (state_nxt_s == ST_CAPTURE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.fifo_rst = fifo_rst_r;
  assign bus.wren     = wren_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.clamped  = clamped_r;
  assign bus.wr_count = wr_count_r;
  assign bus.state    = state_r;

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_capture_ctrl
// Drives capture scenarios (directed and $urandom) and compares every cycle's
// outputs against a timeline model: from the arm cycle, the trig pattern and
// the abort cycle it derives the FLUSH / WAIT / DELAY / CAPTURE / DONE windows
// with plain arithmetic and predicts state, flags and wr_count per cycle.
// ----------------------------------------------------------------------------
module tb_fifo_capture_ctrl;

  localparam int DEPTH = 8192;
  localparam int CNT_W = 14;
  localparam int DLY_W = 16;
  localparam int R     = 8;
  localparam int TA    = 512;
`ifdef FIFO_CAPTURE_TRIG_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   prev_wr;
  bit   prev_clp;

  fifo_capture_ctrl_if #(.CNT_W(CNT_W), .DLY_W(DLY_W)) bus ();

  fifo_capture_ctrl #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .DLY_W(DLY_W), .RST_CYCLES(R)
  ) dut (
    .wrclk(clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {bus.state, bus.fifo_rst, bus.wren, bus.busy, bus.done, bus.clamped};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ab_sel: -1 no abort, -2 random abort cycle, -3 abort with the arm,
  //         >=0 abort on capture cycle cs+ab_sel.
  task automatic run_scen(input int sc, input int d, input logic [7:0] fl_bits,
                          input bit lvl, input int hold, input int lgap,
                          input int hdur, input int ab_sel, input bit extra_arm);
    bit   tr [TA];
    int   idx, t, n, cs, ce, ds, ab, ea, last, lim, k, kk, st, wr;
    bit   clp;
    logic [7:0] ev;

    for (int i = 0; i < TA; i++) tr[i] = 1'b0;
    for (int i = 1; i <= R; i++) tr[i] = fl_bits[i-1];
    idx = R + 1;
    for (int i = 0; i < hold; i++) begin tr[idx] = lvl;  idx++; end
    for (int i = 0; i < lgap; i++) begin tr[idx] = 1'b0; idx++; end
    for (int i = 0; i < hdur; i++) begin tr[idx] = 1'b1; idx++; end

    n   = (sc == 0 || sc > DEPTH) ? DEPTH : sc;
    clp = (sc > DEPTH);
    t   = -1;
    for (int i = R + 1; i < TA; i++) begin
      if (t < 0 && tr[i] && (!EDGE || !tr[i-1])) t = i;
    end
    cs = t + d + 1;
    ce = cs + n - 1;
    ds = ce + 1;

    if (ab_sel == -1)      ab = -1;
    else if (ab_sel == -2) ab = $urandom_range(0, ds + 1);
    else if (ab_sel == -3) ab = 0;
    else                   ab = cs + ab_sel;

    lim = ds - 1;
    if (ab >= 0 && ab < lim) lim = ab;
    ea = (extra_arm && lim >= 1) ? $urandom_range(1, lim) : -1;
    last = (ab >= 0) ? ab + 3 : ds + 2;

    for (int c = 0; c < last; c++) begin
      bus.arm   = (c == 0) || (c == ea);
      bus.abort = (c == ab);
      bus.trig  = (c < TA) ? tr[c] : 1'b0;
      if (c == 0) begin
        bus.sample_count = CNT_W'(sc);
        bus.trig_delay   = DLY_W'(d);
      end else begin
        bus.sample_count = CNT_W'($urandom);
        bus.trig_delay   = DLY_W'($urandom);
      end
      tick();
      k = c + 1;
      if (ab == 0) begin
        ev = {3'd0, 4'b0000, prev_clp};
        wr = prev_wr;
      end else begin
        if (ab > 0 && k > ab) begin
          st = 0;
          kk = ab + 1;
        end else begin
          kk = k;
          if (k <= R)       st = 1;
          else if (k <= t)  st = 2;
          else if (k < cs)  st = 3;
          else if (k <= ce) st = 4;
          else              st = 5;
        end
        wr = kk - cs;
        if (wr < 0) wr = 0;
        if (wr > n) wr = n;
        ev = {st[2:0], (st == 1), (st == 4), (st >= 1 && st <= 4), (st == 5), clp};
      end
      check_val("ctl", {24'd0, obs_vec()}, {24'd0, ev});
      check_val("wr_count", {18'd0, bus.wr_count}, wr);
    end
    prev_wr   = wr;
    prev_clp  = (ab == 0) ? prev_clp : clp;
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    bus.trig  = 1'b0;
  endtask

  initial begin
    int wait_ok;
    n_cmp = 0;
    n_err = 0;
    prev_wr  = 0;
    prev_clp = 1'b0;
    rst = 1'b1;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.trig = 1'b0;
    bus.sample_count = '0;
    bus.trig_delay = '0;
    repeat (3) tick();
    check_val("reset_ctl", {24'd0, obs_vec()}, 32'd0);
    check_val("reset_wr", {18'd0, bus.wr_count}, 32'd0);
    rst = 1'b0;
    tick();

    // basic: 16 samples, no delay, trig at cycle 12
    run_scen(16, 0, 8'h00, 1'b0, 0, 3, 1, -1, 1'b0);
    // delay of 5
    run_scen(4, 5, 8'h00, 1'b0, 0, 2, 1, -1, 1'b0);
    // length bounds
    run_scen(0, 0, 8'h00, 1'b0, 0, 1, 1, -1, 1'b0);
    run_scen(10000, 1, 8'h00, 1'b0, 0, 1, 1, -1, 1'b0);
    // abort on 100th write of 1000, then re-arm
    run_scen(1000, 0, 8'h00, 1'b0, 0, 2, 3, 99, 1'b0);
    run_scen(16, 0, 8'h00, 1'b0, 0, 3, 1, -1, 1'b0);
    // ignored arm during capture/busy and trig during flush
    run_scen(16, 0, 8'hA5, 1'b0, 0, 3, 1, -1, 1'b1);
    // trig held through flush and into WAIT_TRIG, then fall and rise
    run_scen(6, 0, 8'hFF, 1'b1, 4, 2, 3, -1, 1'b0);
    // abort together with arm
    run_scen(8, 2, 8'h00, 1'b0, 0, 1, 1, -3, 1'b0);

    for (int s = 0; s < 24; s++) begin
      run_scen($urandom_range(1, 40), $urandom_range(0, 12), 8'($urandom),
               1'($urandom_range(0, 1)), $urandom_range(0, 5),
               $urandom_range(1, 4), $urandom_range(1, 6),
               ($urandom_range(0, 2) == 0) ? -2 : -1, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a capture
    bus.sample_count = CNT_W'(20);
    bus.trig_delay   = DLY_W'(0);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    wait_ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!wait_ok) begin
        bus.trig = (i >= 11);
        tick();
        if (bus.wren) wait_ok = 1;
      end
    end
    check_val("wait_wren", wait_ok, 1);
    tick();
    rst = 1'b1;
    tick();
    check_val("midrst_ctl", {24'd0, obs_vec()}, 32'd0);
    check_val("midrst_wr", {18'd0, bus.wr_count}, 32'd0);
    rst = 1'b0;
    bus.trig = 1'b0;
    prev_wr  = 0;
    prev_clp = 1'b0;
    tick();
    run_scen(16, 0, 8'h00, 1'b0, 0, 3, 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
